wrr_slice_arbiter: RTL and testbench

Weighted round-robin arbiter that shares one memory port among `N_REQ` CPU requesters. Each requester owns a time slice whose length, in cycles, is set per requester at run time through a small configuration write port. Priority rotates on every handover, and an idle requester forfeits the rest of its slice. The block sits between the CPU request lines and the memory-port mux, and drives the mux select with a registered one-hot grant.

---
 rtl/wrr_slice_arbiter.sv | 127 ++++++++++++
 tb/tb_wrr_slice_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/wrr_slice_arbiter.sv
// Weighted round-robin arbiter with per-requester run-time slice quotas and a registered one-hot grant.
// Define ARB_LOCK_EN to let lock[owner] hold off quota expiry.
module wrr_slice_arbiter #(
    parameter int N_REQ     = 4,
    parameter int QW        = 4,
    parameter int DEF_QUOTA = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [N_REQ-1:0]           lock,
    input  logic                       cfg_we,
    input  logic [$clog2(N_REQ)-1:0]   cfg_id,
    input  logic [QW-1:0]              cfg_quota,
    output logic [N_REQ-1:0]           grant,
    output logic                       grant_valid,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       slice_end
);

    localparam int IW = $clog2(N_REQ);

    localparam logic IDLE = 1'b0;
    localparam logic OWN  = 1'b1;

    logic              state;
    logic [IW-1:0]     ptr;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     winner;
    logic [IW-1:0]     next_ptr;
    logic [QW-1:0]     cnt;
    logic [QW-1:0]     limit;
    logic [QW-1:0]     quota [N_REQ];
    logic [N_REQ-1:0]  cand;
    logic              found;
    logic              owner_req;
    logic              expire;
    logic              lock_hold;
    logic              take_grant;
    logic              release_idle;

    // A stored quota of zero still grants a single cycle.
    function automatic logic [QW-1:0] eff_quota(input logic [QW-1:0] q);
        return (q == '0) ? QW'(1) : q;
    endfunction

    // The owner is masked out, so "found" means another requester is waiting.
    always_comb begin
        cand   = req & ~grant;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = IW'((int'(ptr) + i) % N_REQ);
            if (!found && cand[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign next_ptr  = (winner == IW'(N_REQ - 1)) ? '0 : winner + 1'b1;
    assign owner_req = req[grant_id];
    assign expire    = (cnt == limit - 1'b1);

`ifdef ARB_LOCK_EN
    assign lock_hold = lock[grant_id];
`else
    // lock is accepted but has no effect in this build.
    assign lock_hold = (|lock) & 1'b0;
`endif

    assign take_grant   = found && ((state == IDLE) ||
                                    !owner_req || (expire && !lock_hold));
    assign release_idle = (state == OWN) && !owner_req && !found;
    assign slice_end    = (state == OWN) &&
                          (!owner_req || (expire && found && !lock_hold));

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
            ptr         <= '0;
            cnt         <= '0;
            limit       <= QW'(1);
            for (int i = 0; i < N_REQ; i++) begin
                quota[i] <= QW'(DEF_QUOTA);
            end
        end else begin
            // Nonblocking write: a slice starting on this same edge sees the old quota.
            if (cfg_we && (int'(cfg_id) < N_REQ)) begin
                quota[cfg_id] <= cfg_quota;
            end

            if (take_grant) begin
                state       <= OWN;
                grant       <= N_REQ'(1) << winner;
                grant_valid <= 1'b1;
                grant_id    <= winner;
                ptr         <= next_ptr;
                cnt         <= '0;
                limit       <= eff_quota(quota[winner]);
            end else if (release_idle) begin
                state       <= IDLE;
                grant       <= '0;
                grant_valid <= 1'b0;
                grant_id    <= '0;
                cnt         <= '0;
            end else if (state == OWN) begin
                // At the last slice cycle with a contender, cnt only gets here when locked; it holds.
                if (expire) begin
                    if (!found) begin
                        cnt   <= '0;
                        limit <= eff_quota(quota[grant_id]);
                    end
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_wrr_slice_arbiter.sv
// Directed self-checking bench for wrr_slice_arbiter (N_REQ=4, QW=4, DEF_QUOTA=4).
// Expectations for the lock scenario depend on whether ARB_LOCK_EN is defined.
module tb_wrr_slice_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [3:0] lock;
    logic       cfg_we;
    logic [1:0] cfg_id;
    logic [3:0] cfg_quota;
    logic [3:0] grant;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       slice_end;

    int checks;
    int failures;
    int cyc;

    wrr_slice_arbiter #(
        .N_REQ(4),
        .QW(4),
        .DEF_QUOTA(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .lock(lock),
        .cfg_we(cfg_we),
        .cfg_id(cfg_id),
        .cfg_quota(cfg_quota),
        .grant(grant),
        .grant_valid(grant_valid),
        .grant_id(grant_id),
        .slice_end(slice_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] l,
                                 input logic we, input logic [1:0] id,
                                 input logic [3:0] q);
        req       = r;
        lock      = l;
        cfg_we    = we;
        cfg_id    = id;
        cfg_quota = q;
    endtask

    function automatic logic [1:0] onehotIdx(input logic [3:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) r = 2'(i);
        end
        return r;
    endfunction

    // Called just after a rising edge with inputs already set; checks mid-cycle, then advances.
    task automatic expectCycle(input string name, input logic [3:0] g, input logic se);
        string tag;
        tag = $sformatf("%s c%0d", name, cyc);
        #4;
        checkOutput({tag, " grant"}, 32'(grant), 32'(g));
        checkOutput({tag, " grant_valid"}, 32'(grant_valid), 32'(|g));
        checkOutput({tag, " grant_id"}, 32'(grant_id), 32'(onehotIdx(g)));
        checkOutput({tag, " slice_end"}, 32'(slice_end), 32'(se));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic resetDut();
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        cyc = 0;
        expectCycle("reset", 4'b0000, 1'b0);
        reset = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        reset    = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0);

        // Two requesters at default quota alternate in 4-cycle slices.
        resetDut();
        applyStimulus(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("alt", 4'b0000, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            expectCycle("alt", (((c - 1) / 4) % 2 == 1) ? 4'b0010 : 4'b0001,
                        ((c - 1) % 4) == 3);
        end

        // Quota write to id0 on the edge its slice starts loads the old value.
        resetDut();
        applyStimulus(4'b0011, 4'b0000, 1'b1, 2'd0, 4'd2);
        expectCycle("quota", 4'b0000, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 1'b1, 2'd1, 4'd2);
        expectCycle("quota", 4'b0001, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("quota", 4'b0001, 1'b0);
        expectCycle("quota", 4'b0001, 1'b0);
        expectCycle("quota", 4'b0001, 1'b1);
        expectCycle("quota", 4'b0010, 1'b0);
        expectCycle("quota", 4'b0010, 1'b1);
        expectCycle("quota", 4'b0001, 1'b0);
        expectCycle("quota", 4'b0001, 1'b1);
        expectCycle("quota", 4'b0010, 1'b0);
        expectCycle("quota", 4'b0010, 1'b1);

        // Stored quota 0 behaves as a 1-cycle slice.
        resetDut();
        applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd2, 4'd0);
        expectCycle("q0", 4'b0000, 1'b0);
        applyStimulus(4'b0101, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("q0", 4'b0000, 1'b0);
        for (int c = 2; c <= 5; c++) expectCycle("q0", 4'b0001, c == 5);
        expectCycle("q0", 4'b0100, 1'b1);
        for (int c = 7; c <= 10; c++) expectCycle("q0", 4'b0001, c == 10);
        expectCycle("q0", 4'b0100, 1'b1);

        // Owner drops req: grant ends after the next edge; a lone requester keeps the port.
        resetDut();
        applyStimulus(4'b0001, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("early", 4'b0000, 1'b0);
        expectCycle("early", 4'b0001, 1'b0);
        expectCycle("early", 4'b0001, 1'b0);
        applyStimulus(4'b0000, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("early", 4'b0001, 1'b1);
        expectCycle("early", 4'b0000, 1'b0);
        expectCycle("early", 4'b0000, 1'b0);
        applyStimulus(4'b0001, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("alone", 4'b0000, 1'b0);
        for (int c = 0; c < 12; c++) expectCycle("alone", 4'b0001, 1'b0);

        // Pointer sits after req2, so req3 beats req0.
        resetDut();
        applyStimulus(4'b0100, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("ptr", 4'b0000, 1'b0);
        applyStimulus(4'b1001, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("ptr", 4'b0100, 1'b1);
        for (int c = 2; c <= 5; c++) expectCycle("ptr", 4'b1000, c == 5);
        expectCycle("ptr", 4'b0001, 1'b0);

        // Reset in the 2nd cycle of a quota-2 slice restores default quotas.
        resetDut();
        applyStimulus(4'b0000, 4'b0000, 1'b1, 2'd1, 4'd2);
        expectCycle("midrst", 4'b0000, 1'b0);
        applyStimulus(4'b0010, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("midrst", 4'b0000, 1'b0);
        expectCycle("midrst", 4'b0010, 1'b0);
        reset = 1'b1;
        expectCycle("midrst", 4'b0010, 1'b0);
        reset = 1'b0;
        applyStimulus(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("midrst", 4'b0000, 1'b0);
        for (int c = 5; c <= 8; c++)  expectCycle("midrst", 4'b0001, c == 8);
        for (int c = 9; c <= 12; c++) expectCycle("midrst", 4'b0010, c == 12);
        expectCycle("midrst", 4'b0001, 1'b0);

        // Lock on requester 0 while requester 1 contends.
        resetDut();
        applyStimulus(4'b0011, 4'b0001, 1'b0, 2'd0, 4'd0);
        expectCycle("lock", 4'b0000, 1'b0);
`ifdef ARB_LOCK_EN
        for (int c = 1; c <= 8; c++) expectCycle("lock", 4'b0001, 1'b0);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("lock", 4'b0001, 1'b1);
        expectCycle("lock", 4'b0010, 1'b0);
`else
        for (int c = 1; c <= 4; c++) expectCycle("lock", 4'b0001, c == 4);
        for (int c = 5; c <= 8; c++) expectCycle("lock", 4'b0010, c == 8);
        applyStimulus(4'b0011, 4'b0000, 1'b0, 2'd0, 4'd0);
        expectCycle("lock", 4'b0001, 1'b0);
        expectCycle("lock", 4'b0001, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
